// File: rtl/frame_streamer.sv
`default_nettype none
// ============================================================================
// frame_streamer : snapshots payload/timestamp/config on capture and streams a
//                  sequenced, XOR-checksummed frame over a valid/ready port.
// Revision: 1.0
// ============================================================================
module frame_streamer #(
  parameter int PAYLOAD_WORDS = 24,
  parameter int RESOLUTION    = 24,
  parameter int OUT_WIDTH     = 8
) (
  input  logic                                pllclk,
  input  logic                                reset_n,
  input  logic                                capture,
  input  logic [PAYLOAD_WORDS*RESOLUTION-1:0] payload,
  input  logic [63:0]                         timestamp,
  input  logic [47:0]                         config_word,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                frame_done,
  output logic [7:0]                          overrun_count
);

  localparam int PAY_W      = PAYLOAD_WORDS * RESOLUTION;
  localparam int FRAME_W    = 128 + PAY_W;
  localparam int HDR_CHUNKS = 64 / OUT_WIDTH;
  localparam int PAY_CHUNKS = PAY_W / OUT_WIDTH;
  localparam int CNT_W      = $clog2(PAY_CHUNKS + HDR_CHUNKS) + 1;

  localparam logic [CNT_W-1:0] c_hdr_last = CNT_W'(HDR_CHUNKS - 1);
  localparam logic [CNT_W-1:0] c_pay_last = CNT_W'(PAY_CHUNKS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_FOOTER  = 3'd3,
    S_CHECK   = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [FRAME_W-1:0]     r_shift;
  logic [OUT_WIDTH-1:0]   r_csum;
  logic [CNT_W-1:0]       r_cnt;
  logic [15:0]            r_seq;
  logic [7:0]             r_ovr;

  logic [PAY_W-1:0]       w_pay_ord;
  logic [FRAME_W-1:0]     w_frame;
  logic [15:0]            w_seq_hdr;
  logic [OUT_WIDTH-1:0]   w_chunk;
  logic                   w_hs;
  logic                   w_data_state;
  logic                   w_last_chunk;
  logic                   w_check_hs;
  logic                   w_start;
  logic                   w_overrun;

  // Word 0 lives in the LSBs of payload but must leave first, so reorder it to the top.
  for (genvar k = 0; k < PAYLOAD_WORDS; k++) begin : g_pay_order
    assign w_pay_ord[(PAYLOAD_WORDS-1-k)*RESOLUTION +: RESOLUTION] = payload[k*RESOLUTION +: RESOLUTION];
  end

  assign out_valid    = (r_state != S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign w_hs         = out_valid & out_ready;
  assign w_data_state = (r_state == S_HEADER) | (r_state == S_PAYLOAD) | (r_state == S_FOOTER);
  assign w_check_hs   = (r_state == S_CHECK) & w_hs;
  assign w_start      = capture & ((r_state == S_IDLE) | w_check_hs);
  assign w_overrun    = capture & busy & ~w_check_hs;
  assign w_chunk      = r_shift[FRAME_W-1 -: OUT_WIDTH];
  // A back-to-back frame is snapshotted in the same cycle seq increments.
  assign w_seq_hdr    = w_check_hs ? (r_seq + 16'd1) : r_seq;
  assign w_frame      = {w_seq_hdr, config_word, w_pay_ord, timestamp};
  assign frame_done   = w_check_hs & reset_n;
  assign overrun_count = r_ovr;

  always_comb begin
    out_data = '0;
    if (r_state == S_CHECK) begin
      out_data = r_csum;
    end else if (w_data_state) begin
      out_data = w_chunk;
    end
  end

  always_comb begin
    w_last_chunk = 1'b0;
    case (r_state)
      S_HEADER:  w_last_chunk = (r_cnt == c_hdr_last);
      S_PAYLOAD: w_last_chunk = (r_cnt == c_pay_last);
      S_FOOTER:  w_last_chunk = (r_cnt == c_hdr_last);
      default:   w_last_chunk = 1'b0;
    endcase
  end

  always_ff @(posedge pllclk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (capture)               w_state_next = S_HEADER;
      S_HEADER:  if (w_hs && w_last_chunk)  w_state_next = S_PAYLOAD;
      S_PAYLOAD: if (w_hs && w_last_chunk)  w_state_next = S_FOOTER;
      S_FOOTER:  if (w_hs && w_last_chunk)  w_state_next = S_CHECK;
      S_CHECK:   if (w_hs)                  w_state_next = capture ? S_HEADER : S_IDLE;
      default:                              w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pllclk) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_csum  <= '0;
      r_cnt   <= '0;
      r_seq   <= '0;
      r_ovr   <= '0;
    end else begin
      if (w_start) begin
        r_shift <= w_frame;
        r_csum  <= '0;
      end else if (w_data_state && w_hs) begin
        r_shift <= r_shift << OUT_WIDTH;
        r_csum  <= r_csum ^ w_chunk;
      end

      // Chunk index restarts on every field change.
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (w_data_state && w_hs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_check_hs) begin
        r_seq <= r_seq + 16'd1;
      end

      if (w_overrun && (r_ovr != 8'hFF)) begin
        r_ovr <= r_ovr + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_streamer.sv
`default_nettype none
// ============================================================================
// tb_frame_streamer : scoreboard bench for frame_streamer (2 x 24-bit words, 8-bit chunks).
// Revision: 1.0
// ============================================================================
module tb_frame_streamer;

  localparam int PW  = 2;
  localparam int RES = 24;
  localparam int OW  = 8;
  localparam int N   = 23;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                capture;
  logic [PW*RES-1:0]   payload;
  logic [63:0]         timestamp;
  logic [47:0]         cfg;
  logic [OW-1:0]       out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                frame_done;
  logic [7:0]          overrun_count;

  always #5 clk = ~clk;

  frame_streamer #(
    .PAYLOAD_WORDS(PW),
    .RESOLUTION   (RES),
    .OUT_WIDTH    (OW)
  ) dut (
    .pllclk       (clk),
    .reset_n      (reset_n),
    .capture      (capture),
    .payload      (payload),
    .timestamp    (timestamp),
    .config_word  (cfg),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun_count(overrun_count)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } sb_t;

  typedef struct {
    logic [23:0] w0;
    logic [23:0] w1;
    logic [63:0] ts;
    logic [47:0] cfg;
    int          ready_mode;
    logic [7:0]  exp_check;
  } vec_t;

  sb_t         sb[$];
  sb_t         mon_e;
  vec_t        vecs[4];
  logic [7:0]  basic_bytes[N];
  int          errors = 0;
  int          checks = 0;
  int          ready_mode = 1;
  logic [15:0] exp_seq = 16'd0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;
  logic [7:0]  ov_before;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame builder: header, payload words in order, footer, XOR of all of them.
  task automatic push_frame(input logic [23:0] w0, input logic [23:0] w1, input logic [63:0] ts,
                            input logic [47:0] c, input bit use_chk, input logic [7:0] chk_val);
    logic [7:0]  b[N];
    logic [7:0]  x = 8'd0;
    logic [15:0] s = exp_seq;
    sb_t         e;
    b[0] = s[15:8];
    b[1] = s[7:0];
    for (int i = 0; i < 6; i++) b[2+i]  = c[47-8*i -: 8];
    for (int i = 0; i < 3; i++) b[8+i]  = w0[23-8*i -: 8];
    for (int i = 0; i < 3; i++) b[11+i] = w1[23-8*i -: 8];
    for (int i = 0; i < 8; i++) b[14+i] = ts[63-8*i -: 8];
    for (int i = 0; i < N-1; i++) x ^= b[i];
    b[N-1] = use_chk ? chk_val : x;
    for (int i = 0; i < N; i++) begin
      e.data = b[i];
      e.last = (i == N-1);
      sb.push_back(e);
    end
    exp_seq++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit push, input bit use_chk, input logic [7:0] cv);
    capture = 1'b1;
    if (push) push_frame(payload[23:0], payload[47:24], timestamp, cfg, use_chk, cv);
    cyc(1);
    capture = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin
      cyc(1);
      n++;
    end
    checks++;
    if (busy || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d expected idle with 0 pending", name, busy, sb.size());
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Monitor: sampled on the falling edge, between the drive point and the next handshake edge.
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) chk("hold_data", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chunk: got %0h expected no chunk at %0t", out_data, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("chunk", out_data, mon_e.data);
          chk("frame_done", frame_done, mon_e.last);
        end
      end else if (out_valid) begin
        chk("frame_done_stall", frame_done, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    basic_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5,
                    8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56,
                    8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h54};
    // {w0, w1, ts, cfg, ready_mode, expected CHECK chunk} with seq 1..4
    vecs[0] = '{24'hABCDEF, 24'h123456, 64'h0102030405060708, 48'h0000000000A5, 2, 8'h55};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 64'h0, 48'h0, 2, 8'hFD};
    vecs[2] = '{24'h010203, 24'h040506, 64'h0, 48'h0A0B0C0D0E0F, 1, 8'h05};
    vecs[3] = '{24'h000000, 24'h000000, 64'h0, 48'h0, 1, 8'h04};

    reset_n   = 1'b0;
    capture   = 1'b0;
    payload   = '0;
    timestamp = '0;
    cfg       = '0;
    cyc(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_overrun", overrun_count, 0);
    reset_n = 1'b1;
    cyc(1);

    // Basic frame against the literal byte list.
    payload   = {24'h123456, 24'hABCDEF};
    timestamp = 64'h0102030405060708;
    cfg       = 48'h0000000000A5;
    capture   = 1'b1;
    for (int i = 0; i < N; i++) begin
      mon_e.data = basic_bytes[i];
      mon_e.last = (i == N-1);
      sb.push_back(mon_e);
    end
    exp_seq++;
    cyc(1);
    capture = 1'b0;
    chk("start_valid", out_valid, 1);
    chk("start_first", out_data, 8'h00);
    wait_done("basic");

    for (int v = 0; v < 4; v++) begin
      ready_mode = vecs[v].ready_mode;
      payload    = {vecs[v].w1, vecs[v].w0};
      timestamp  = vecs[v].ts;
      cfg        = vecs[v].cfg;
      cyc(1);
      pulse(1'b1, 1'b1, vecs[v].exp_check);
      wait_done("vec");
    end

    // Back-to-back: capture during the CHECK handshake cycle.
    ready_mode = 1;
    payload    = {24'h123456, 24'hABCDEF};
    timestamp  = 64'h0102030405060708;
    cfg        = 48'h0000000000A5;
    cyc(2);
    ov_before = overrun_count;
    pulse(1'b1, 1'b0, 8'h00);
    repeat (22) @(posedge clk);
    #1;
    capture = 1'b1;
    push_frame(payload[23:0], payload[47:24], timestamp, cfg, 1'b0, 8'h00);
    cyc(1);
    capture = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_busy", busy, 1);
    chk("b2b_first", out_data, 8'h00);
    chk("b2b_no_overrun", overrun_count, ov_before);
    wait_done("b2b");

    // Overruns mid-frame, then saturation under a stalled sink.
    pulse(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc(2);
      pulse(1'b0, 1'b0, 8'h00);
    end
    wait_done("overrun");
    chk("overrun_3", overrun_count, 3);
    ready_mode = 0;
    cyc(1);
    pulse(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      pulse(1'b0, 1'b0, 8'h00);
      cyc(1);
    end
    chk("overrun_sat", overrun_count, 255);
    chk("stall_busy", busy, 1);
    ready_mode = 1;
    wait_done("overrun_sat");
    chk("overrun_sat_hold", overrun_count, 255);

    // Reset in the middle of the payload field.
    cyc(1);
    pulse(1'b1, 1'b0, 8'h00);
    cyc(8);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    sb.delete();
    exp_seq = 16'd0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun_count, 0);
    chk("midrst_data", out_data, 0);
    cyc(1);
    pulse(1'b1, 1'b0, 8'h00);
    wait_done("post_reset");

    // Snapshot: inputs change right after the capture edge.
    cyc(1);
    pulse(1'b1, 1'b0, 8'h00);
    payload   = {24'h0F0F0F, 24'h777777};
    timestamp = 64'hDEADBEEFCAFEF00D;
    cfg       = 48'h111111111111;
    wait_done("snapshot");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
